// File: rtl/mul8_dot_acc.sv
// ---------------------------------------------------------------------------
// mul8_dot_acc -- streaming unsigned 8x8 dot-product accumulator.
//
// Operand pairs (A, B) arrive over a valid/ready handshake. Every accepted
// pair flows through a three-stage pipeline:
//   S1  registers A, B and the "this is the vector end" flag
//   S2  registers the exact 16-bit product of the S1 operands
//   S3  adds the product into the ACC_W-bit accumulator (sticky carry-out)
// A vector ends when a pair arrives with in_last set, or when it is the
// LEN-th pair. The block then stops taking input, waits for the end term to
// drain out of S3, and presents the result until downstream takes it.
//
// Ports
//   clk        single clock, all state changes on its rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand pair A/B (and in_last) valid
//   in_ready   block accepts an operand pair this cycle
//   A, B       8-bit unsigned operands
//   in_last    accepted pair is the final term of the vector
//   out_valid  sum/ovf/cnt valid
//   out_ready  downstream accepts the result
//   sum        sum of products modulo 2^ACC_W
//   ovf        sticky: some accumulation carried out of ACC_W bits
//   cnt        number of terms in the result (1..LEN)
// ---------------------------------------------------------------------------

// Exact 8x8 unsigned multiplier cell: a plain shift-and-add over the bits of
// b, giving the full 16-bit product with no truncation or rounding.
module mul8_exact (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p + (16'(a) << i);
            end
        end
    end

endmodule

module mul8_dot_acc #(
    parameter int LEN   = 16,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       A,
    input  logic [7:0]       B,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             ovf,
    output logic [8:0]       cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Term counter value at which an accepted pair is the LEN-th one.
    localparam logic [8:0] LAST_IDX = 9'(LEN - 1);

    state_t             state_q, state_d;

    logic               s1_valid_q, s1_valid_d;
    logic [7:0]         s1_a_q, s1_a_d;
    logic [7:0]         s1_b_q, s1_b_d;
    logic               s1_end_q, s1_end_d;

    logic               s2_valid_q, s2_valid_d;
    logic [15:0]        s2_prod_q, s2_prod_d;
    logic               s2_end_q, s2_end_d;

    logic               s3_end_q, s3_end_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               acc_ovf_q, acc_ovf_d;
    logic [8:0]         term_cnt_q, term_cnt_d;

    logic [ACC_W-1:0]   res_sum_q, res_sum_d;
    logic               res_ovf_q, res_ovf_d;
    logic [8:0]         res_cnt_q, res_cnt_d;

    logic               accept;
    logic               term_is_end;
    logic               load_result;
    logic               clear_vector;
    logic [15:0]        mul_p;
    logic [ACC_W:0]     add_full;

    mul8_exact u_mul (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (mul_p)
    );

    assign accept      = in_valid && in_ready;
    assign term_is_end = in_last || (term_cnt_q == LAST_IDX);

    // Product zero-extended to ACC_W+1 bits so the top bit of the add is the
    // carry out of the accumulator.
    assign add_full = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, s2_prod_q};

    // State register of the RUN / FLUSH / HOLD controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Controller: RUN takes terms until the vector end is accepted, FLUSH
    // waits for that end term to leave S3, HOLD presents the result. The
    // result is captured into dedicated registers on the FLUSH->HOLD step so
    // the outputs read zero after reset and stay put while held.
    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        load_result  = 1'b0;
        clear_vector = 1'b0;
        case (state_q)
            RUN: begin
                in_ready = !rst;
                if (accept && term_is_end) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (s3_end_q) begin
                    load_result = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    clear_vector = 1'b1;
                    state_d      = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Datapath next-state: the pipeline never stalls, so each stage simply
    // takes whatever the previous stage held; valid bits mark bubbles so that
    // empty slots neither add to the sum nor count as terms.
    always_comb begin
        s1_valid_d = accept;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_end_d   = s1_end_q;
        if (accept) begin
            s1_a_d   = A;
            s1_b_d   = B;
            s1_end_d = term_is_end;
        end

        s2_valid_d = s1_valid_q;
        s2_prod_d  = mul_p;
        s2_end_d   = s1_valid_q && s1_end_q;

        s3_end_d   = s2_valid_q && s2_end_q;
        acc_d      = acc_q;
        acc_ovf_d  = acc_ovf_q;
        if (s2_valid_q) begin
            acc_d     = add_full[ACC_W-1:0];
            acc_ovf_d = acc_ovf_q | add_full[ACC_W];
        end

        term_cnt_d = term_cnt_q;
        if (accept) begin
            term_cnt_d = term_cnt_q + 9'd1;
        end

        // The pipeline is empty whenever HOLD is left, so clearing here
        // cannot collide with an in-flight add or acceptance.
        if (clear_vector) begin
            acc_d      = '0;
            acc_ovf_d  = 1'b0;
            term_cnt_d = '0;
        end

        res_sum_d = res_sum_q;
        res_ovf_d = res_ovf_q;
        res_cnt_d = res_cnt_q;
        if (load_result) begin
            res_sum_d = acc_q;
            res_ovf_d = acc_ovf_q;
            res_cnt_d = term_cnt_q;
        end
    end

    // Pipeline, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_end_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_end_q   <= 1'b0;
            s3_end_q   <= 1'b0;
            acc_q      <= '0;
            acc_ovf_q  <= 1'b0;
            term_cnt_q <= '0;
            res_sum_q  <= '0;
            res_ovf_q  <= 1'b0;
            res_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_end_q   <= s1_end_d;
            s2_valid_q <= s2_valid_d;
            s2_prod_q  <= s2_prod_d;
            s2_end_q   <= s2_end_d;
            s3_end_q   <= s3_end_d;
            acc_q      <= acc_d;
            acc_ovf_q  <= acc_ovf_d;
            term_cnt_q <= term_cnt_d;
            res_sum_q  <= res_sum_d;
            res_ovf_q  <= res_ovf_d;
            res_cnt_q  <= res_cnt_d;
        end
    end

    assign sum = res_sum_q;
    assign ovf = res_ovf_q;
    assign cnt = res_cnt_q;

endmodule

// File: tb/tb_mul8_dot_acc.sv
// ---------------------------------------------------------------------------
// tb_mul8_dot_acc -- self-checking bench for mul8_dot_acc.
//
// Two instances (ACC_W=24 and ACC_W=16, both LEN=16) share one stimulus
// stream. A behavioural model tracks the exact integer dot product of the
// current vector, its term count and when its result is due; every cycle the
// outputs of both instances are compared with it. Directed tests add literal
// expectations that pin the model itself.
// ---------------------------------------------------------------------------
module tb_mul8_dot_acc;

    localparam int LEN = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  a_drv = '0;
    logic [7:0]  b_drv = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready24, in_ready16;
    logic        out_valid24, out_valid16;
    logic [23:0] sum24;
    logic [15:0] sum16;
    logic        ovf24, ovf16;
    logic [8:0]  cnt24, cnt16;

    int checks = 0;
    int errors = 0;

    // Model state: exact sum of the current vector, its term count, whether a
    // result is owed, and how many edges since its end term was accepted.
    longint modelSum = 0;
    int     modelCnt = 0;
    bit     modelPending = 1'b0;
    int     modelAge = 0;
    bit     modelResultSeen = 1'b0;
    logic   cmpExpValid;

    always #5 clk = ~clk;

    mul8_dot_acc #(.LEN(LEN), .ACC_W(24)) dut24 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready24),
        .A         (a_drv),
        .B         (b_drv),
        .in_last   (in_last),
        .out_valid (out_valid24),
        .out_ready (out_ready),
        .sum       (sum24),
        .ovf       (ovf24),
        .cnt       (cnt24)
    );

    mul8_dot_acc #(.LEN(LEN), .ACC_W(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready16),
        .A         (a_drv),
        .B         (b_drv),
        .in_last   (in_last),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .sum       (sum16),
        .ovf       (ovf16),
        .cnt       (cnt16)
    );

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model update: terms are taken whenever no result is owed; a result
    // becomes visible three edges after its end term and is retired by the
    // out_valid/out_ready handshake.
    always @(posedge clk) begin
        if (rst) begin
            modelSum        <= 0;
            modelCnt        <= 0;
            modelPending    <= 1'b0;
            modelAge        <= 0;
            modelResultSeen <= 1'b0;
        end else if (modelPending) begin
            if (modelAge == 3 && out_ready) begin
                modelPending <= 1'b0;
                modelSum     <= 0;
                modelCnt     <= 0;
                modelAge     <= 0;
            end else if (modelAge < 3) begin
                modelAge <= modelAge + 1;
                if (modelAge == 2) begin
                    modelResultSeen <= 1'b1;
                end
            end
        end else if (in_valid) begin
            modelSum <= modelSum + longint'(a_drv) * longint'(b_drv);
            modelCnt <= modelCnt + 1;
            if (in_last || modelCnt + 1 == LEN) begin
                modelPending <= 1'b1;
                modelAge     <= 0;
            end
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        #1;
        cmpExpValid = modelPending && (modelAge == 3);
        compare("out_valid24", out_valid24, cmpExpValid);
        compare("out_valid16", out_valid16, cmpExpValid);
        compare("in_ready24", in_ready24, !rst && !modelPending);
        compare("in_ready16", in_ready16, !rst && !modelPending);
        if (cmpExpValid) begin
            compare("model sum24", sum24, modelSum % 64'h1000000);
            compare("model ovf24", ovf24, modelSum >= 64'h1000000);
            compare("model cnt24", cnt24, modelCnt);
            compare("model sum16", sum16, modelSum % 64'h10000);
            compare("model ovf16", ovf16, modelSum >= 64'h10000);
            compare("model cnt16", cnt16, modelCnt);
        end else if (!modelResultSeen) begin
            compare("idle sum24", sum24, 0);
            compare("idle sum16", sum16, 0);
            compare("idle cnt24", cnt24, 0);
        end
    end

    // Drive one pair (called at a falling edge) and return at the falling
    // edge just after the rising edge that accepted it.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        a_drv    = a;
        b_drv    = b;
        in_last  = last;
        while (!in_ready24 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready24) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept timeout: got in_ready 0 expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitForValid(input string name);
        int waited = 0;
        while (!out_valid24 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!out_valid24) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s valid timeout: got out_valid 0 expected 1", name);
        end
    endtask

    // Wait for a result, check literal values on both instances (and the
    // latency in falling edges if lat >= 0), then take it.
    task automatic checkOutput(input string name, input longint s24, input bit o24,
                               input longint s16, input bit o16, input int c, input int lat);
        int waited = 0;
        while (!out_valid24 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!out_valid24) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got out_valid 0 expected 1", name);
        end else begin
            if (lat >= 0) begin
                compare({name, " latency"}, waited, lat);
            end
            compare({name, " sum24"}, sum24, s24);
            compare({name, " ovf24"}, ovf24, o24);
            compare({name, " cnt24"}, cnt24, c);
            compare({name, " sum16"}, sum16, s16);
            compare({name, " ovf16"}, ovf16, o16);
            compare({name, " cnt16"}, cnt16, c);
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        longint refSum;
        int     gap;
        logic [7:0] ra, rb;

        repeat (3) @(negedge clk);
        compare("reset in_ready", in_ready24, 0);
        compare("reset out_valid", out_valid24, 0);
        compare("reset sum", sum24, 0);
        compare("reset cnt", cnt24, 0);
        rst = 1'b0;
        @(negedge clk);
        compare("post-reset in_ready", in_ready24, 1);

        // Short vector with in_last.
        $display("[TB] three-term vector");
        applyStimulus(8'd1, 8'd2, 1'b0);
        applyStimulus(8'd3, 8'd4, 1'b0);
        applyStimulus(8'd5, 8'd6, 1'b1);
        checkOutput("basic", 44, 0, 44, 0, 3, 3);

        // Full-length vector ends on its own; a 17th pair must wait.
        $display("[TB] full-length vector");
        out_ready = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            applyStimulus(8'd255, 8'd255, 1'b0);
        end
        in_valid = 1'b1;
        a_drv    = 8'd1;
        b_drv    = 8'd1;
        repeat (8) begin
            @(negedge clk);
            compare("no 17th accept", in_ready24, 0);
        end
        checkOutput("len16", 1040400, 0, 57360, 1, 16, -1);
        applyStimulus(8'd1, 8'd1, 1'b1);
        checkOutput("after len16", 1, 0, 1, 0, 1, 3);

        // Carry out of the narrow accumulator.
        $display("[TB] overflow vector");
        applyStimulus(8'd255, 8'd255, 1'b0);
        applyStimulus(8'd255, 8'd255, 1'b1);
        checkOutput("overflow", 130050, 0, 64514, 1, 2, 3);

        // Result held with downstream stalled; input ignored meanwhile.
        $display("[TB] held result");
        out_ready = 1'b0;
        applyStimulus(8'd3, 8'd5, 1'b0);
        applyStimulus(8'd4, 8'd4, 1'b1);
        waitForValid("hold");
        in_valid = 1'b1;
        a_drv    = 8'd200;
        b_drv    = 8'd200;
        in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            compare("hold sum", sum24, 31);
            compare("hold cnt", cnt24, 2);
            compare("hold ovf", ovf24, 0);
            compare("hold in_ready", in_ready24, 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("hold", 31, 0, 31, 0, 2, -1);
        applyStimulus(8'd7, 8'd7, 1'b1);
        checkOutput("after hold", 49, 0, 49, 0, 1, 3);

        // Reset mid-vector discards the partial sum.
        $display("[TB] reset mid-vector");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'(i + 1), 8'(i + 2), 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'd2, 8'd3, 1'b1);
        checkOutput("after abort", 6, 0, 6, 0, 1, 3);

        // Reset while holding a result drops it.
        $display("[TB] reset in hold");
        out_ready = 1'b0;
        applyStimulus(8'd9, 8'd9, 1'b1);
        waitForValid("hold abort");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        compare("dropped out_valid", out_valid24, 0);
        compare("dropped sum", sum24, 0);
        out_ready = 1'b1;

        // Random terms with random bubbles.
        $display("[TB] random gaps");
        refSum = 0;
        for (int i = 0; i < 8; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            refSum += longint'(ra) * longint'(rb);
            applyStimulus(ra, rb, i == 7);
        end
        checkOutput("random", refSum % 64'h1000000, refSum >= 64'h1000000,
                    refSum % 64'h10000, refSum >= 64'h10000, 8, 3);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mul8_dot_acc.md
MUL8_DOT_ACC -- requirements
Module: mul8_dot_acc

Interface
REQ-001 SHALL have parameter LEN, default 16, maximum terms per dot product (legal 2..256).
REQ-002 SHALL have parameter ACC_W, default 24, accumulator/result width in bits (legal 16..32).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair A/B (and in_last) valid.
REQ-006 SHALL have port in_ready  output  1  block accepts an operand pair this cycle.
REQ-007 SHALL have port A  input  8  unsigned multiplicand.
REQ-008 SHALL have port B  input  8  unsigned multiplier.
REQ-009 SHALL have port in_last  input  1  marks the accepted pair as the final term of the vector.
REQ-010 SHALL have port out_valid  output  1  result fields valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port sum  output  ACC_W  sum of A*B products modulo 2^ACC_W.
REQ-013 SHALL have port ovf  output  1  sticky: some accumulation carried out of ACC_W bits.
REQ-014 SHALL have port cnt  output  9  number of terms in the result (1..LEN).

Function
REQ-015 SHALL use one clock, clk; rst SHALL be synchronous and active-high; no other clock or async reset.
REQ-016 SHALL compute each product with the team's exact 8x8 unsigned multiplier cell (16-bit product, zero error).
REQ-017 SHALL accept a term when in_valid && in_ready are both high at a rising edge.
REQ-018 SHALL pipeline as: S1 registers A, B, last flag; S2 registers the 16-bit product; S3 adds it into the accumulator.
REQ-019 SHALL zero-extend each product to ACC_W + 1 bits before the add; set ovf if bit ACC_W of the add is 1; keep ACC_W LSBs.
REQ-020 SHALL treat a term as the vector end if in_last=1 or it is term number LEN (term counter = LEN-1 at acceptance).
REQ-021 SHALL implement states RUN, FLUSH, HOLD; in_ready = 1 only in RUN.
REQ-022 RUN -> FLUSH on acceptance of the vector-end term; in_ready drops the following cycle.
REQ-023 FLUSH -> HOLD when the vector-end term leaves S3; out_valid rises 3 cycles after the end-term acceptance edge.
REQ-024 HOLD: sum, ovf, cnt and out_valid SHALL stay stable until out_valid && out_ready.
REQ-025 HOLD -> RUN on the handshake edge; accumulator, ovf and term counter clear on that edge; in_ready = 1 the next cycle.
REQ-026 Bubbles (in_valid low in RUN) SHALL NOT add to sum or advance cnt; S1/S2 valid bits SHALL track occupancy.
REQ-027 Accumulation SHALL NOT stall in RUN or FLUSH; only HOLD blocks input.
REQ-028 in_valid in FLUSH or HOLD SHALL be ignored; A, B, in_last are don't-care when not accepted.
REQ-029 cnt SHALL equal the accepted term count of the vector, including the end term.

Reset
REQ-030 While rst=1 at an edge: state = RUN, S1/S2 valid = 0, accumulator = 0, ovf = 0, cnt = 0, out_valid = 0.
REQ-031 in_ready SHALL be 0 in any cycle where rst=1, and 1 in the first cycle after rst deasserts.
REQ-032 rst asserted mid-vector or in HOLD SHALL discard all partial and pending results; no out_valid pulse may follow.
REQ-033 sum SHALL read 0 after reset until the first result.

Verification
REQ-034 Bench: 3 terms (1,2),(3,4),(5,6 with in_last), out_ready=1 -> out_valid 3 cycles after the last acceptance, sum=44, cnt=3, ovf=0.
REQ-035 Bench: LEN=16, 16 back-to-back terms (255,255), no in_last -> sum=1040400, cnt=16, ovf=0; the 17th pair is not accepted until the handoff.
REQ-036 Bench: ACC_W=16, 2 terms (255,255) with in_last on the 2nd -> sum=64514, ovf=1, cnt=2.
REQ-037 Bench: out_ready held low 5 cycles in HOLD -> sum/cnt/ovf stable, in_ready=0 throughout; the next vector (7,7 last) gives sum=49, cnt=1, ovf=0.
REQ-038 Bench: 4 terms accepted, rst pulsed 1 cycle, then (2,3 last) -> single result sum=6, cnt=1; no result for the aborted vector.
REQ-039 Bench: random in_valid gaps on 8 random terms -> sum equals the reference dot product modulo 2^ACC_W; cnt=8.
